// File: rtl/sync_debounce.sv
// sync_debounce: synchronizer plus debounce qualifier for one asynchronous level.
// The raw level d passes through a SYNC_STAGES-deep flop chain. A four-state FSM
// then requires STABLE_CYCLES+1 consecutive equal synchronized samples before
// the clean output q changes. When q changes, a one-cycle rise or fall strobe
// is produced. All outputs are registered.
// Optional build macro SYNC_GLITCH_CNT_EN adds glitch_cnt, an 8-bit saturating
// count of aborted qualifications.
module sync_debounce #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1),
    parameter bit          RESET_VAL     = 1'b0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       d,
    output logic       q,
    output logic       rise,
    output logic       fall,
    output logic       busy
`ifdef SYNC_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);

    typedef enum logic [1:0] {
        LOW        = 2'd0,
        CHECK_HIGH = 2'd1,
        HIGH       = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam state_t           RESET_STATE = RESET_VAL ? HIGH : LOW;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic                   s;

    // The oldest stage of the chain is the only sample the qualifier ever sees.
    assign s = sync_q[SYNC_STAGES-1];

    // Shift the raw level into the synchronizer chain, newest sample at bit 0.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Qualification FSM: leave a stable state on the first differing sample,
    // commit after STABLE_CYCLES further agreeing samples, abort on any reversal.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            LOW: begin
                if (s) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!s) begin
                    state_d = CHECK_LOW;
                    cnt_d   = '0;
                end
            end
            CHECK_LOW: begin
                if (s) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
                level_d = RESET_VAL;
            end
        endcase
        busy_d = (state_d == CHECK_HIGH) || (state_d == CHECK_LOW);
    end

    // State, counter, synchronizer and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync_q  <= {SYNC_STAGES{RESET_VAL}};
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            level_q <= RESET_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = level_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

`ifdef SYNC_GLITCH_CNT_EN
    logic [7:0] gcnt_q, gcnt_d;
    logic       abort;

    // An abort is a qualification that falls back to the state it started from.
    always_comb begin
        abort  = ((state_q == CHECK_HIGH) && (state_d == LOW)) ||
                 ((state_q == CHECK_LOW)  && (state_d == HIGH));
        gcnt_d = gcnt_q;
        if (abort && (gcnt_q != 8'hFF)) begin
            gcnt_d = gcnt_q + 8'd1;
        end
    end

    // Glitch counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            gcnt_q <= 8'd0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign glitch_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed stimulus for sync_debounce with defaults.
// A run-length model of the qualifier is compared against the DUT after every
// rising edge. Literal expectations at known edges pin the model itself.
module tb_sync_debounce;

    localparam int SS = 2;
    localparam int SC = 4;
    localparam bit RV = 1'b0;

    logic clk = 1'b0;
    logic nrst;
    logic d;
    logic q, rise, fall, busy;
`ifdef SYNC_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: delayed copies of d, current level, run of disagreeing samples.
    logic hist [SS];
    logic mq, mr, mf, mbusy;
    int   mrun;
    int   mg;

    sync_debounce #(
        .SYNC_STAGES  (SS),
        .STABLE_CYCLES(SC),
        .RESET_VAL    (RV)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .d   (d),
        .q   (q),
        .rise(rise),
        .fall(fall),
        .busy(busy)
`ifdef SYNC_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt)
`endif
    );

    // Free-running clock, half-period 100.
    always #100 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic dv, input logic nv);
        @(negedge clk);
        d    = dv;
        nrst = nv;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #2;
    endtask

    // One edge of the model: q flips on the (SC+1)th consecutive sample that
    // disagrees with it; a shorter disagreeing run is a rejected glitch.
    task automatic modelStep();
        logic s;
        mr = 1'b0;
        mf = 1'b0;
        if (!nrst) begin
            for (int i = 0; i < SS; i++) hist[i] = RV;
            mq   = RV;
            mrun = 0;
            mg   = 0;
        end else begin
            s = hist[SS-1];
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = d;
            if (s != mq) begin
                mrun++;
                if (mrun == SC + 1) begin
                    mq   = s;
                    mr   = s;
                    mf   = !s;
                    mrun = 0;
                end
            end else begin
                if (mrun > 0 && mg < 255) mg++;
                mrun = 0;
            end
        end
        mbusy = (mrun > 0);
    endtask

    // Compare process: step the model and check every output after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            modelStep();
            checkOutput("model_q", q, mq);
            checkOutput("model_rise", rise, mr);
            checkOutput("model_fall", fall, mf);
            checkOutput("model_busy", busy, mbusy);
`ifdef SYNC_GLITCH_CNT_EN
            checkOutput("model_glitch", glitch_cnt, mg);
`endif
        end
    end

    // Directed sequence with hand-computed expectations at each edge.
    initial begin
        d    = 1'b0;
        nrst = 1'b0;

        // Reset held two edges with d=1.
        applyStimulus(1'b1, 1'b0);
        stepEdge();
        applyStimulus(1'b1, 1'b0);
        stepEdge();
        checkOutput("rst_q", q, 0);
        checkOutput("rst_rise", rise, 0);
        checkOutput("rst_fall", fall, 0);
        checkOutput("rst_busy", busy, 0);
`ifdef SYNC_GLITCH_CNT_EN
        checkOutput("rst_glitch", glitch_cnt, 0);
`endif

        // Release with d held high: q and rise at E6, busy E2..E5.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i <= 7; i++) begin
            stepEdge();
            checkOutput("rel_q", q, (i >= 6));
            checkOutput("rel_rise", rise, (i == 6));
            checkOutput("rel_fall", fall, 0);
            checkOutput("rel_busy", busy, (i >= 2 && i <= 5));
        end

        // Fall path: q drops with one-cycle fall at E6.
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i <= 7; i++) begin
            stepEdge();
            checkOutput("fall_q", q, (i < 6));
            checkOutput("fall_fall", fall, (i == 6));
            checkOutput("fall_rise", rise, 0);
            checkOutput("fall_busy", busy, (i >= 2 && i <= 5));
        end

        // Glitch: d high for three periods only.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i <= 10; i++) begin
            if (i == 3) applyStimulus(1'b0, 1'b1);
            stepEdge();
            checkOutput("glitch_q", q, 0);
            checkOutput("glitch_rise", rise, 0);
            checkOutput("glitch_busy", busy, (i >= 2 && i <= 4));
        end
`ifdef SYNC_GLITCH_CNT_EN
        checkOutput("glitch_cnt_one", glitch_cnt, 1);
`endif

        // Boundary: a pulse of exactly SC samples is rejected.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i <= 9; i++) begin
            if (i == 4) applyStimulus(1'b0, 1'b1);
            stepEdge();
            checkOutput("edge4_q", q, 0);
            checkOutput("edge4_busy", busy, (i >= 2 && i <= 5));
        end

        // Boundary: SC+1 samples are accepted, then an immediate fall follows.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i <= 12; i++) begin
            if (i == 5) applyStimulus(1'b0, 1'b1);
            stepEdge();
            checkOutput("edge5_q", q, (i >= 6 && i < 11));
            checkOutput("edge5_rise", rise, (i == 6));
            checkOutput("edge5_fall", fall, (i == 11));
        end

        // Reset in the middle of a qualification aborts it silently.
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i <= 3; i++) stepEdge();
        checkOutput("mid_busy_before", busy, 1);
        applyStimulus(1'b1, 1'b0);
        stepEdge();
        checkOutput("mid_busy", busy, 0);
        checkOutput("mid_q", q, 0);
        checkOutput("mid_rise", rise, 0);
`ifdef SYNC_GLITCH_CNT_EN
        checkOutput("mid_glitch", glitch_cnt, 0);
`endif
        applyStimulus(1'b0, 1'b1);
        repeat (8) stepEdge();
        checkOutput("mid_after_q", q, 0);

        // Saturation: 300 short pulses, each two samples wide.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(1'b1, 1'b1);
            stepEdge();
            stepEdge();
            applyStimulus(1'b0, 1'b1);
            stepEdge();
            stepEdge();
        end
        repeat (4) stepEdge();
        checkOutput("sat_q", q, 0);
`ifdef SYNC_GLITCH_CNT_EN
        checkOutput("sat_glitch", glitch_cnt, 255);
`endif

        $display("[TB] model glitch count: %0d", mg);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
